ifetch_parcel_ctrl: RTL and testbench

Fetch sequencer and parcel buffer for the compressed-ISA front end. It owns the instruction-fetch address and issues word reads to the icache. Returned words are split into 16-bit parcels and held in a 4-entry queue. It presents one aligned instruction per cycle to IF/ID: compressed parcels and 32-bit instructions that straddle word boundaries are both handled here, so the IF stage never re-fetches the same word.

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/parcel_queue.sv | 70 +++++++
 rtl/ifetch_parcel_ctrl.sv | 120 ++++++++++++
 tb/tb_ifetch_parcel_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants and helpers for the instruction-fetch parcel
// front end.
//   PARCEL_W      width of one instruction parcel (halfword)
//   QDEPTH        number of parcel slots in the fetch queue
//   FULL_OP       low opcode bits [9:8] of a parcel that starts a 32-bit instruction
//   is_compressed returns 1 when a parcel is a complete 16-bit instruction
package ifetch_pkg;

   localparam int PARCEL_W = 16;
   localparam int QDEPTH   = 4;

   localparam logic [1:0] FULL_OP = 2'b11;

   function automatic logic is_compressed(input logic [PARCEL_W-1:0] parcel);
      return parcel[9:8] != FULL_OP;
   endfunction

endpackage

// File: rtl/parcel_queue.sv
// parcel_queue: 4-entry x 16-bit parcel FIFO built as a shift buffer.
// Slot 0 is always the oldest parcel, so the head instruction can be read
// directly from slots 0 and 1.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the queue)
//   flush           discard all entries; any push/pop this cycle is dropped
//   pop_n  [1:0]    parcels removed from the head this cycle (0..2)
//   push_n [1:0]    parcels appended this cycle (0..2)
//   push_d0/push_d1 first / second parcel to append
//   head0/head1     slot 0 / slot 1 contents
//   count  [2:0]    number of valid parcels (0..4)
module parcel_queue
   import ifetch_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic [1:0]          pop_n,
   input  logic [1:0]          push_n,
   input  logic [PARCEL_W-1:0] push_d0,
   input  logic [PARCEL_W-1:0] push_d1,
   output logic [PARCEL_W-1:0] head0,
   output logic [PARCEL_W-1:0] head1,
   output logic [2:0]          count
);

   logic [PARCEL_W-1:0] q     [QDEPTH];
   logic [PARCEL_W-1:0] q_nxt [QDEPTH];
   logic [2:0]          cnt;
   logic [2:0]          keep;
   logic [2:0]          src;

   // Survivors of the pop shift down to slot 0; pushed parcels land right
   // behind them. The caller never pushes into a queue that would overflow.
   always_comb begin
      keep = cnt - {1'b0, pop_n};
      src  = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         q_nxt[i] = q[i];
         if (3'(i) < keep) begin
            src      = 3'(i) + {1'b0, pop_n};
            q_nxt[i] = q[src[1:0]];
         end else if (3'(i) == keep && push_n != 2'd0) begin
            q_nxt[i] = push_d0;
         end else if (3'(i) == keep + 3'd1 && push_n == 2'd2) begin
            q_nxt[i] = push_d1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         cnt <= '0;
      end else begin
         cnt <= cnt - {1'b0, pop_n} + {1'b0, push_n};
      end
   end

   // Parcel storage carries no reset; only the count decides validity.
   always_ff @(posedge clk) begin
      for (int i = 0; i < QDEPTH; i++) begin
         q[i] <= q_nxt[i];
      end
   end

   assign head0 = q[0];
   assign head1 = q[1];
   assign count = cnt;

endmodule

// File: rtl/ifetch_parcel_ctrl.sv
// ifetch_parcel_ctrl: fetch sequencer and parcel buffer for the compressed-ISA
// front end. Issues word reads to the icache, splits returned words into
// parcels, and presents one aligned instruction per cycle to IF/ID.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   redirect/redirect_pc taken branch/jump: flush and refetch from redirect_pc
//   mem_req/mem_addr     word read request and word address [31:2]
//   mem_ready/mem_rdata  icache accepts the request and returns the word
//   ins_valid/ins        complete instruction (compressed: {16'b0, parcel})
//   ins_is_c/ins_pc      compressed flag and PC of ins
//   ins_ready            IF/ID consumes ins
module ifetch_parcel_ctrl
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_req,
   output logic [29:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        ins_valid,
   output logic [31:0] ins,
   output logic        ins_is_c,
   output logic [31:0] ins_pc,
   input  logic        ins_ready
);

   localparam logic [31:0] RESET_PC_HW = RESET_PC & 32'hFFFF_FFFE;

   logic [29:0]          fpc;
   logic                 skip;
   // PC of the queue head, kept as a full byte address with bit 0 held at 0.
   logic [31:0]          dpc;

   logic [31:0]          redir_pc_hw;
   logic [PARCEL_W-1:0]  head0;
   logic [PARCEL_W-1:0]  head1;
   logic [2:0]           q_count;
   logic                 head_c;
   logic                 ins_avail;
   logic                 want_word;
   logic                 fire;
   logic                 take;
   logic [1:0]           pop_n;
   logic [1:0]           push_n;
   logic [PARCEL_W-1:0]  push_d0;
   logic [PARCEL_W-1:0]  push_d1;

   assign redir_pc_hw = redirect_pc & 32'hFFFF_FFFE;

   assign head_c    = is_compressed(head0);
   assign ins_avail = (q_count >= 3'd1 && head_c) || q_count >= 3'd2;
   // Only fetch while a full word (2 parcels) is guaranteed to fit.
   assign want_word = q_count <= 3'd2;
   assign fire      = want_word && mem_ready;
   assign take      = ins_avail && ins_ready;

   assign pop_n   = !take ? 2'd0 : (head_c ? 2'd1 : 2'd2);
   assign push_n  = !fire ? 2'd0 : (skip ? 2'd1 : 2'd2);
   // After a redirect to an odd halfword the offset-0 parcel is dropped.
   assign push_d0 = skip ? mem_rdata[15:0] : mem_rdata[31:16];
   assign push_d1 = mem_rdata[15:0];

   parcel_queue u_queue (
      .clk     (clk),
      .rst     (rst),
      .flush   (redirect),
      .pop_n   (pop_n),
      .push_n  (push_n),
      .push_d0 (push_d0),
      .push_d1 (push_d1),
      .head0   (head0),
      .head1   (head1),
      .count   (q_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc  <= RESET_PC[31:2];
         skip <= RESET_PC[1];
         dpc  <= RESET_PC_HW;
      end else if (redirect) begin
         fpc  <= redir_pc_hw[31:2];
         skip <= redir_pc_hw[1];
         dpc  <= redir_pc_hw;
      end else begin
         if (fire) begin
            fpc  <= fpc + 30'd1;
            skip <= 1'b0;
         end
         if (take) begin
            dpc <= dpc + (head_c ? 32'd2 : 32'd4);
         end
      end
   end

   // Outputs depend only on state, with rst forcing the idle values.
   always_comb begin
      mem_req   = 1'b0;
      mem_addr  = fpc;
      ins_valid = 1'b0;
      ins_is_c  = 1'b0;
      ins       = '0;
      ins_pc    = RESET_PC_HW;
      if (!rst) begin
         mem_req   = want_word;
         ins_valid = ins_avail;
         ins_is_c  = head_c;
         ins_pc    = dpc;
         if (ins_avail) begin
            ins = head_c ? {16'h0000, head0} : {head0, head1};
         end
      end
   end

endmodule

// File: tb/tb_ifetch_parcel_ctrl.sv
module tb_ifetch_parcel_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [29:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        ins_valid;
   logic [31:0] ins;
   logic        ins_is_c;
   logic [31:0] ins_pc;
   logic        ins_ready;

   always #5 clk = ~clk;

   ifetch_parcel_ctrl #(.RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .ins_valid   (ins_valid),
      .ins         (ins),
      .ins_is_c    (ins_is_c),
      .ins_pc      (ins_pc),
      .ins_ready   (ins_ready)
   );

   typedef struct {
      logic [31:0] ins;
      logic        c;
      logic [31:0] pc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cur_mode = 3;
   logic [31:0] tbl [4];

   // Memory image: mode 1 all-full, 2 all-compressed, 3 random mix, 4 small table.
   function automatic logic [31:0] mem_word(input logic [29:0] a, input int mode);
      logic [31:0] w;
      if (mode == 4) return tbl[a[1:0]];
      w = {2'b00, a} * 32'h9E37_79B1 + 32'h7F4A_7C15;
      w = w ^ (w >> 13);
      if (mode == 1) begin
         w[25:24] = 2'b11;
         w[9:8]   = 2'b11;
      end else if (mode == 2) begin
         w[25] = 1'b0;
         w[9]  = 1'b0;
      end
      return w;
   endfunction

   function automatic logic [15:0] parcel_at(input logic [30:0] h, input int mode);
      logic [31:0] w;
      w = mem_word(h[30:1], mode);
      return h[0] ? w[15:0] : w[31:16];
   endfunction

   // Expected instruction stream from a start PC, decoded straight from memory.
   task automatic restart(input logic [31:0] pc, input int mode);
      logic [30:0] h;
      logic [15:0] p0;
      logic [15:0] p1;
      exp_t        e;
      cur_mode = mode;
      exp_q.delete();
      h = pc[31:1];
      repeat (64) begin
         p0   = parcel_at(h, mode);
         e.pc = {h, 1'b0};
         if (p0[9:8] != 2'b11) begin
            e.ins = {16'h0000, p0};
            e.c   = 1'b1;
            h     = h + 31'd1;
         end else begin
            p1    = parcel_at(h + 31'd1, mode);
            e.ins = {p0, p1};
            e.c   = 1'b0;
            h     = h + 31'd2;
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic apply(input logic do_rst, input logic redir, input logic [31:0] rpc,
                        input int mode, input logic mr, input logic ir);
      rst         = do_rst;
      redirect    = redir;
      redirect_pc = rpc;
      mem_ready   = mr;
      ins_ready   = ir;
      if (do_rst)     restart(RESET_PC, mode);
      else if (redir) restart(rpc, mode);
      mem_rdata = mem_word(mem_addr, cur_mode);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic do_rst, input logic redir, input logic [31:0] rpc,
                      input int mode, input logic mr, input logic ir);
      apply(do_rst, redir, rpc, mode, mr, ir);
      tick();
   endtask

   // Monitor: scoreboard pops, hold-stability and reset-value checks.
   initial begin
      exp_t        e;
      logic        hold_ins = 1'b0;
      logic        hold_mem = 1'b0;
      logic [31:0] p_ins = '0;
      logic [31:0] p_pc = '0;
      logic        p_c = 1'b0;
      logic [29:0] p_addr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("rst_mem_req", {31'b0, mem_req}, 32'd0);
            check("rst_ins_valid", {31'b0, ins_valid}, 32'd0);
            check("rst_ins", ins, 32'd0);
            check("rst_ins_is_c", {31'b0, ins_is_c}, 32'd0);
            check("rst_ins_pc", ins_pc, RESET_PC);
            hold_ins = 1'b0;
            hold_mem = 1'b0;
         end else begin
            if (hold_ins) begin
               check("hold_valid", {31'b0, ins_valid}, 32'd1);
               check("hold_ins", ins, p_ins);
               check("hold_pc", ins_pc, p_pc);
               check("hold_is_c", {31'b0, ins_is_c}, {31'b0, p_c});
            end
            if (hold_mem) begin
               check("hold_mem_req", {31'b0, mem_req}, 32'd1);
               check("hold_mem_addr", {2'b0, mem_addr}, {2'b0, p_addr});
            end
            if (!ins_valid) check("idle_ins_zero", ins, 32'd0);
            if (ins_valid && ins_ready && !redirect) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL sb_empty: got ins %h pc %h expected none", ins, ins_pc);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_ins", ins, e.ins);
                  check("sb_is_c", {31'b0, ins_is_c}, {31'b0, e.c});
                  check("sb_pc", ins_pc, e.pc);
               end
            end
            hold_ins = ins_valid && !ins_ready && !redirect;
            hold_mem = mem_req && !mem_ready && !redirect;
            p_ins    = ins;
            p_pc     = ins_pc;
            p_c      = ins_is_c;
            p_addr   = mem_addr;
         end
      end
   end

   // Stimulus
   initial begin
      int          drops;
      int          seg;
      logic        r_rst;
      logic        r_red;
      logic [31:0] r_pc;
      tbl[0] = 32'h0001_0313;   // {C, F_lo}
      tbl[1] = 32'h1234_0002;   // {F_hi, C}
      tbl[2] = 32'h0004_0006;
      tbl[3] = 32'h0008_000A;
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
      mem_ready = 1'b0; ins_ready = 1'b0; mem_rdata = '0;

      // All-full stream from reset: one word per cycle, no bubbles.
      cyc(1, 0, 0, 1, 1, 1);
      cyc(1, 0, 0, 1, 1, 1);
      for (int j = 0; j <= 10; j++) begin
         apply(0, 0, 0, 1, 1, 1);
         check("full_req", {31'b0, mem_req}, 32'd1);
         check("full_addr", {2'b0, mem_addr}, j);
         check("full_valid", {31'b0, ins_valid}, (j >= 1) ? 32'd1 : 32'd0);
         if (j >= 1) check("full_pc", ins_pc, 4 * (j - 1));
         tick();
      end

      // All-compressed stream: one per cycle, mem_req drops when queue is full.
      cyc(0, 1, 0, 2, 1, 1);
      drops = 0;
      for (int j = 1; j <= 14; j++) begin
         apply(0, 0, 0, 2, 1, 1);
         if (j >= 2) begin
            check("c_valid", {31'b0, ins_valid}, 32'd1);
            check("c_pc", ins_pc, 2 * (j - 2));
         end
         if (!mem_req) drops++;
         tick();
      end
      check("c_req_drop", {31'b0, drops > 0}, 32'd1);

      // Mixed: C@0, {F_lo,F_hi}@2, C@6.
      cyc(0, 1, 0, 4, 1, 1);
      cyc(0, 0, 0, 4, 1, 1);
      apply(0, 0, 0, 4, 1, 1);
      check("mix0_ins", ins, 32'h0000_0001);
      check("mix0_pc", ins_pc, 32'd0);
      tick();
      apply(0, 0, 0, 4, 1, 1);
      check("mix1_ins", ins, 32'h0313_1234);
      check("mix1_pc", ins_pc, 32'd2);
      tick();
      apply(0, 0, 0, 4, 1, 1);
      check("mix2_ins", ins, 32'h0000_0002);
      check("mix2_pc", ins_pc, 32'd6);
      tick();
      repeat (4) cyc(0, 0, 0, 4, 1, 1);

      // Redirect to an offset-2 full instruction.
      cyc(0, 1, 32'h0000_0102, 1, 1, 1);
      apply(0, 0, 0, 1, 1, 1);
      check("r102_req", {31'b0, mem_req}, 32'd1);
      check("r102_addr0", {2'b0, mem_addr}, 32'h40);
      check("r102_v1", {31'b0, ins_valid}, 32'd0);
      tick();
      apply(0, 0, 0, 1, 1, 1);
      check("r102_addr1", {2'b0, mem_addr}, 32'h41);
      check("r102_v2", {31'b0, ins_valid}, 32'd0);
      tick();
      apply(0, 0, 0, 1, 1, 1);
      check("r102_v3", {31'b0, ins_valid}, 32'd1);
      check("r102_pc", ins_pc, 32'h0000_0102);
      tick();
      repeat (4) cyc(0, 0, 0, 1, 1, 1);

      // ins_ready low for 5 cycles.
      cyc(0, 1, 32'h0000_0200, 3, 1, 1);
      repeat (4) cyc(0, 0, 0, 3, 1, 1);
      repeat (5) cyc(0, 0, 0, 3, 1, 0);
      apply(0, 0, 0, 3, 1, 0);
      check("stall_req_off", {31'b0, mem_req}, 32'd0);
      tick();
      repeat (10) cyc(0, 0, 0, 3, 1, 1);

      // Redirect, then reset, during fire + pop.
      repeat (6) cyc(0, 0, 0, 3, 1, 1);
      cyc(0, 1, 32'h0000_1006, 3, 1, 1);
      repeat (8) cyc(0, 0, 0, 3, 1, 1);
      cyc(1, 0, 0, 1, 1, 1);
      repeat (8) cyc(0, 0, 0, 1, 1, 1);

      // Address wrap.
      cyc(0, 1, 32'hFFFF_FFFA, 3, 1, 1);
      repeat (10) cyc(0, 0, 0, 3, 1, 1);

      // Random traffic.
      seg = 0;
      for (int k = 0; k < 1500; k++) begin
         r_rst = ($urandom % 200) == 0;
         r_red = (seg >= 50) || (($urandom % 30) == 0);
         r_pc  = $urandom;
         if (($urandom % 8) == 0) r_pc = 32'hFFFF_FFF0 | ($urandom % 16);
         cyc(r_rst, r_red, r_pc, 1 + int'($urandom % 4),
             ($urandom % 4) != 0, ($urandom % 4) != 0);
         seg = (r_rst || r_red) ? 0 : seg + 1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
